unsigned_sqrt_iterative: RTL
============================

Name: unsigned_sqrt_iterative

Overview:
Responder (sqrt end) of the unsigned_sqrt_interface. A requester (the FP sqrt path) pulses start with a radicand. This block computes floor(sqrt(radicand)) and the remainder, two radicand bits per cycle, using the restoring digit-by-digit method. It sits behind the FP square-root unit, in the same way the iterative divider sits behind unsigned_division_interface.

Parameters:
DATA_WIDTH, 32, radicand/result/remainder width; must be even and >= 4
ITERATIONS (localparam), DATA_WIDTH/2, cycles per operation

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  sqrt_input.start; launch a new operation
radicand  input  DATA_WIDTH  sqrt_input.radicand; sampled only when start=1
done  output  1  sqrt_output.done; one-cycle pulse when result is valid
result  output  DATA_WIDTH  sqrt_output.result; floor(sqrt(radicand)), upper DATA_WIDTH/2 bits always 0
remainder  output  DATA_WIDTH  sqrt_output.remainder; radicand - result^2, zero-extended

Behaviour:
- Reset (async, rst=1): busy=0, done=0, result=0, remainder=0, counter=0, shift register=0. Reset mid-operation abandons the operation; no done follows.
- Internal state:
  - x_shift (DATA_WIDTH): radicand shifted left 2 per step.
  - rem_r (ITERATIONS+2 bits).
  - root_r (ITERATIONS bits).
  - cnt (clog2(ITERATIONS) bits).
  - busy.
- Step function f(rem, root, x):
  - rem_n = {rem, x[MSB:MSB-1]}, truncated to ITERATIONS+2 bits
  - trial = {root, 2'b01}
  - if rem_n >= trial: rem' = rem_n - trial, root' = {root, 1}
  - else: rem' = rem_n, root' = {root, 0}
  - x' = x << 2
  - All comparisons are unsigned and widths are exact; no overflow is possible at ITERATIONS+2 bits.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE, start=1 at edge E0:
  - Step 1 is applied to rem=0, root=0, x=radicand.
  - cnt=1, busy=1.
- RUN, each edge with start=0:
  - Apply one step; cnt++.
  - At the edge where step ITERATIONS completes: busy=0, done<=1, result<={0, root'}, remainder<={0, rem'}.
- Latency: start high in cycle t gives done high in cycle t+ITERATIONS (cycle t+16 for DATA_WIDTH=32). done is high for exactly one cycle.
- Back-to-back: start may be asserted in the same cycle done is high. The new operation begins and the previous outputs stay valid in that cycle.
- start while busy (RUN): the current operation is aborted and restarted with the new radicand as in IDLE. No done is produced for the aborted operation. Latency counts from the new start.
- result/remainder registers change only at completion or reset. They hold their value indefinitely between operations, including across aborts.
- No ready signal exists. The requester must not expect more than one done per start.
- Output invariant at done: result^2 + remainder == radicand, and remainder <= 2*result.

Decomposition:
- Shared types: the interface structs already live in the shared types package. Add localparam SQRT_ITERATIONS = DATA_WIDTH/2 there for reuse by the FP sqrt requester.
- One natural sub-module: unsigned_sqrt_step, purely combinational, implementing f(). It is instantiated once and kept separate so it can be unrolled later for a radix-4 variant.
- Top module holds the FSM, counter and output registers.

Test Plan:
- Reset mid-run: start radicand=1000000, assert rst at cycle t+5 for one cycle -> done never pulses; result=0, remainder=0; later start 16 -> done at +16, result=4, rem=0.
- Basic values, each with 16-cycle latency and done exactly one cycle wide:
  - 0 -> result 0, rem 0
  - 1 -> result 1, rem 0
  - 2 -> result 1, rem 1
  - 15 -> result 3, rem 6
  - 1000000 -> result 1000, rem 0
- Max boundary: radicand=32'hFFFFFFFF -> result 32'h0000FFFF, remainder 32'h0001FFFE.
- Abort: start 15 at t, start 100 at t+7 -> no done at t+16; done at t+23 with result 10, rem 0; outputs unchanged before then.
- Back-to-back: start 16 at t, start 17 at t+16 (same cycle as done) -> done at t+16 (result 4, rem 0) and at t+32 (result 4, rem 1).
- Random: 10k random radicands with random gaps and random aborts -> invariant result^2+remainder==radicand and remainder<=2*result at every done; exactly one done per non-aborted start.

Source files
------------

// File: rtl/unsigned_sqrt_iterative_pkg.sv
// Shared types for the unsigned square-root interface.
// The FP sqrt requester reuses SQRT_ITERATIONS to size its wait.
package unsigned_sqrt_iterative_pkg;

  localparam int SQRT_DATA_WIDTH = 32;
  localparam int SQRT_ITERATIONS = SQRT_DATA_WIDTH / 2;

  typedef struct packed {
    logic                       start;
    logic [SQRT_DATA_WIDTH-1:0] radicand;
  } sqrt_input_t;

  typedef struct packed {
    logic                       done;
    logic [SQRT_DATA_WIDTH-1:0] result;
    logic [SQRT_DATA_WIDTH-1:0] remainder;
  } sqrt_output_t;

  typedef enum logic {
    SQRT_IDLE = 1'b0,
    SQRT_RUN  = 1'b1
  } sqrt_state_t;

endpackage

// File: rtl/unsigned_sqrt_step.sv
// One restoring digit-by-digit square-root step: consumes two radicand bits,
// produces one root bit and the updated partial remainder.
module unsigned_sqrt_step #(
  parameter int ITERATIONS = 16
) (
  input  logic [ITERATIONS+1:0] rem_in,
  input  logic [ITERATIONS-1:0] root_in,
  input  logic [1:0]            x_top,
  output logic [ITERATIONS+1:0] rem_out,
  output logic [ITERATIONS-1:0] root_out
);

  localparam int REM_W  = ITERATIONS + 2;
  localparam int WIDE_W = ITERATIONS + 4;

  // The partial remainder never exceeds 2*root, so its top bits are always
  // zero; working at the untruncated width is numerically identical.
  logic [WIDE_W-1:0] rem_wide;
  logic [WIDE_W-1:0] trial_wide;
  logic              take;

  assign rem_wide   = {rem_in, x_top};
  assign trial_wide = {2'b00, root_in, 2'b01};
  assign take       = (rem_wide >= trial_wide);

  assign rem_out  = take ? REM_W'(rem_wide - trial_wide) : REM_W'(rem_wide);
  assign root_out = {root_in[ITERATIONS-2:0], take};

endmodule

// File: rtl/unsigned_sqrt_iterative.sv
// Iterative unsigned square root: floor(sqrt(radicand)) and remainder,
// two radicand bits per cycle, restartable by a new start at any time.
module unsigned_sqrt_iterative
  import unsigned_sqrt_iterative_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] radicand,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int ITERATIONS = DATA_WIDTH / 2;
  localparam int CNT_W      = $clog2(ITERATIONS);
  localparam int REM_W      = ITERATIONS + 2;

  sqrt_state_t           state_reg;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [REM_W-1:0]      rem_reg;
  logic [ITERATIONS-1:0] root_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic [DATA_WIDTH-1:0] x_src;
  logic [REM_W-1:0]      rem_src;
  logic [ITERATIONS-1:0] root_src;
  logic [REM_W-1:0]      rem_next;
  logic [ITERATIONS-1:0] root_next;
  logic                  last_step;

  // A start (idle or mid-run) seeds the step from the fresh radicand.
  always_comb begin
    x_src    = x_reg;
    rem_src  = rem_reg;
    root_src = root_reg;
    if (start) begin
      x_src    = radicand;
      rem_src  = '0;
      root_src = '0;
    end
  end

  unsigned_sqrt_step #(
    .ITERATIONS(ITERATIONS)
  ) u_step (
    .rem_in  (rem_src),
    .root_in (root_src),
    .x_top   (x_src[DATA_WIDTH-1:DATA_WIDTH-2]),
    .rem_out (rem_next),
    .root_out(root_next)
  );

  assign last_step = (state_reg == SQRT_RUN) && !start &&
                     (cnt_reg == CNT_W'(ITERATIONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SQRT_IDLE;
      x_reg     <= '0;
      rem_reg   <= '0;
      root_reg  <= '0;
      cnt_reg   <= '0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start || state_reg == SQRT_RUN) begin
        x_reg    <= x_src << 2;
        rem_reg  <= rem_next;
        root_reg <= root_next;
      end
      if (start) begin
        state_reg <= SQRT_RUN;
        cnt_reg   <= CNT_W'(1);
      end else if (last_step) begin
        state_reg <= SQRT_IDLE;
        cnt_reg   <= '0;
        done      <= 1'b1;
        result    <= DATA_WIDTH'(root_next);
        remainder <= DATA_WIDTH'(rem_next);
      end else if (state_reg == SQRT_RUN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule
